// File: rtl/zebra_stop_fsm_pkg.sv
// Shared types and constants for the zebra-crossing stop path.
package zebra_pkg;

  localparam int unsigned IMG_WIDTH     = 320;
  localparam int unsigned IMG_HEIGHT    = 240;
  localparam int unsigned ZEBRA_W_COUNT = $clog2(IMG_WIDTH * IMG_HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_STOP      = 3'd2,
    ST_RELEASING = 3'd3,
    ST_FAULT     = 3'd4
  } zebra_state_t;

  // Stop is asserted whenever the vehicle must stay halted, including fail-safe.
  function automatic logic state_is_stop(zebra_state_t s);
    return (s == ST_STOP) || (s == ST_RELEASING) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/zebra_stop_fsm_if.sv
// Verdict input and filtered stop output bundle.
interface zebra_stop_fsm_if #(
  parameter int unsigned W_COUNT = zebra_pkg::ZEBRA_W_COUNT
);
  logic               detection_valid;
  logic               crossing_detected;
  logic [W_COUNT-1:0] white_count;
  logic               stop;
  logic               fault;
  logic [2:0]         state;
  logic [W_COUNT-1:0] count_q;
  logic               count_update;

  modport master (
    output detection_valid, crossing_detected, white_count,
    input  stop, fault, state, count_q, count_update
  );

  modport slave (
    input  detection_valid, crossing_detected, white_count,
    output stop, fault, state, count_q, count_update
  );
endinterface

// File: rtl/zebra_stop_fsm_watchdog.sv
// Verdict-stream watchdog: pulses expired once after TIMEOUT_CYCLES-1 quiet edges.
module frame_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on kick, otherwise count up and park at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on the edge the counter reaches its last value; a kick wins.
  assign expired = !kick && (cnt_q == CNT_PRE);

endmodule

// File: rtl/zebra_stop_fsm.sv
// Frame-level hysteresis, minimum hold and fail-safe watchdog for the stop command.
module zebra_stop_fsm
  import zebra_pkg::*;
#(
  parameter int unsigned W_COUNT         = ZEBRA_W_COUNT,
  parameter int unsigned ENTER_FRAMES    = 3,
  parameter int unsigned EXIT_FRAMES     = 5,
  parameter int unsigned MIN_HOLD_FRAMES = 30,
  parameter int unsigned TIMEOUT_CYCLES  = 2_000_000
) (
  input logic             clk,
  input logic             rst,
  zebra_stop_fsm_if.slave bus
);

  localparam int unsigned STREAK_MAX = (ENTER_FRAMES > EXIT_FRAMES) ? ENTER_FRAMES : EXIT_FRAMES;
  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam int unsigned HW = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;
  localparam logic [SW-1:0] ENTER_LAST = SW'(ENTER_FRAMES);
  localparam logic [SW-1:0] EXIT_LAST  = SW'(EXIT_FRAMES);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD_FRAMES);

  zebra_state_t       state_q;
  logic [SW-1:0]      streak_q;
  logic [HW-1:0]      hold_q;
  logic [W_COUNT-1:0] cap_q;
  logic               upd_q;
  logic               sample;
  logic               p;
  logic               wd_expired;

  assign sample = bus.detection_valid;
  assign p      = bus.crossing_detected;

  frame_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (sample),
    .expired (wd_expired)
  );

  // White-count capture for the HEX display, with a one-cycle update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= sample;
      if (sample) begin
        cap_q <= bus.white_count;
      end
    end
  end

  // Verdict FSM: moves only on samples, except for watchdog entry into FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
      hold_q   <= '0;
    end else if (sample) begin
      case (state_q)
        ST_IDLE: begin
          if (p) begin
            state_q  <= ST_ARMING;
            streak_q <= SW'(1);
          end
        end
        ST_ARMING: begin
          if (!p) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
          end else if (streak_q + SW'(1) == ENTER_LAST) begin
            state_q  <= ST_STOP;
            streak_q <= '0;
            hold_q   <= '0;
          end else begin
            streak_q <= streak_q + SW'(1);
          end
        end
        ST_STOP: begin
          if (hold_q < HOLD_MAX) begin
            hold_q <= hold_q + HW'(1);
          end
          if (!p && (hold_q >= HOLD_MAX)) begin
            if (EXIT_FRAMES == 1) begin
              state_q  <= ST_IDLE;
              streak_q <= '0;
            end else begin
              state_q  <= ST_RELEASING;
              streak_q <= SW'(1);
            end
          end
        end
        ST_RELEASING: begin
          if (p) begin
            // Hold stays saturated so a later negative can resume release at once.
            state_q  <= ST_STOP;
            streak_q <= '0;
          end else if (streak_q + SW'(1) == EXIT_LAST) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
          end else begin
            streak_q <= streak_q + SW'(1);
          end
        end
        ST_FAULT: begin
          streak_q <= '0;
          if (p) begin
            state_q <= ST_STOP;
            hold_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          streak_q <= '0;
        end
      endcase
    end else if (wd_expired) begin
      state_q <= ST_FAULT;
    end
  end

  // Outputs decode the state register only; no input reaches them combinationally.
  assign bus.stop         = state_is_stop(state_q);
  assign bus.fault        = (state_q == ST_FAULT);
  assign bus.state        = state_q;
  assign bus.count_q      = cap_q;
  assign bus.count_update = upd_q;

endmodule

// File: tb/tb_zebra_stop_fsm.sv
// Scoreboard bench for zebra_stop_fsm with short hysteresis and timeout settings.
module tb_zebra_stop_fsm;

  localparam int unsigned W     = 17;
  localparam int unsigned ENTER = 3;
  localparam int unsigned EXIT  = 2;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned TMO   = 100;

  typedef struct packed {
    logic [2:0]   st;
    logic         stop;
    logic         fault;
    logic [W-1:0] cnt;
    logic         upd;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  zebra_stop_fsm_if #(.W_COUNT(W)) bus ();

  zebra_stop_fsm #(
    .W_COUNT         (W),
    .ENTER_FRAMES    (ENTER),
    .EXIT_FRAMES     (EXIT),
    .MIN_HOLD_FRAMES (HOLD),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           fault_cycles = 0;
  obs_t         sb[$];
  logic [W-1:0] last_wc;

  always @(negedge clk) if (bus.fault === 1'b1) fault_cycles = fault_cycles + 1;

  function automatic obs_t expect_of(logic [2:0] st, logic [W-1:0] cnt, logic upd);
    obs_t o;
    o.st    = st;
    o.stop  = (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
    o.fault = (st == 3'd4);
    o.cnt   = cnt;
    o.upd   = upd;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st    = bus.state;
    o.stop  = bus.stop;
    o.fault = bus.fault;
    o.cnt   = bus.count_q;
    o.upd   = bus.count_update;
    return o;
  endfunction

  // Apply one verdict 'gap' edges after the previous one and queue its expected result.
  task automatic drive(input int gap, input logic pv, input logic [W-1:0] wc, input logic [2:0] st);
    repeat (gap - 1) @(posedge clk);
    @(negedge clk);
    bus.detection_valid   = 1'b1;
    bus.crossing_detected = pv;
    bus.white_count       = wc;
    last_wc = wc;
    sb.push_back(expect_of(st, wc, 1'b1));
    @(posedge clk);
    #1;
    bus.detection_valid   = 1'b0;
    bus.crossing_detected = 1'($urandom_range(0, 1));
    bus.white_count       = W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.detection_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_wc = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    obs_t e, got;
    @(negedge clk);
    rst = 1'b1;
    #1;
    e = expect_of(3'd0, '0, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", got, e);
    end
    do_reset();
  endtask

  task automatic run_table(input string name, input int n, input logic [15:0] ptab,
                           input logic [2:0] stab[16], input int gap);
    obs_t e, got;
    for (int i = 0; i < n; i++) begin
      drive(gap, ptab[i], W'($urandom_range(0, 76799)), stab[i]);
      e = sb.pop_front();
      got = observe();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, got, e);
      end
    end
  endtask

  task automatic test_entry();
    logic [2:0]  st[16] = '{1, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] pt = 16'b0000_0000_0011_1011;
    do_reset();
    run_table("entry", 6, pt, st, 10);
  endtask

  task automatic test_min_hold();
    logic [2:0]  st[16] = '{1, 1, 2, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] pt = 16'b0000_0000_0000_0111;
    do_reset();
    run_table("min_hold", 9, pt, st, 10);
  endtask

  task automatic test_release_abort();
    logic [2:0]  st[16] = '{1, 1, 2, 2, 2, 2, 2, 3, 2, 3, 0, 0, 0, 0, 0, 0};
    logic [15:0] pt = 16'b0000_0001_0000_0111;
    do_reset();
    run_table("release_abort", 11, pt, st, 10);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  st[16] = '{1, 1, 2, 2, 2, 2, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [15:0] pt = 16'b0000_0010_0000_0111;
    do_reset();
    run_table("back_to_back", 10, pt, st, 1);
  endtask

  task automatic test_watchdog();
    obs_t e, got;
    do_reset();
    drive(2, 1'b0, W'(5), 3'd0);
    e = sb.pop_front();
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_kick: got %h expected %h", got, e);
    end
    repeat (TMO - 2) @(posedge clk);
    #1;
    e = expect_of(3'd0, last_wc, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_pre_expiry: got %h expected %h", got, e);
    end
    @(posedge clk);
    #1;
    e = expect_of(3'd4, last_wc, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_expiry: got %h expected %h", got, e);
    end
    drive(10, 1'b0, W'(77), 3'd0);
    e = sb.pop_front();
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_recover_idle: got %h expected %h", got, e);
    end
    repeat (TMO - 1) @(posedge clk);
    #1;
    e = expect_of(3'd4, last_wc, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_expiry2: got %h expected %h", got, e);
    end
    drive(3, 1'b1, W'(88), 3'd2);
    e = sb.pop_front();
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wd_recover_stop: got %h expected %h", got, e);
    end
  endtask

  task automatic test_coincidence();
    obs_t e, got;
    int   f0;
    do_reset();
    drive(2, 1'b0, W'(11), 3'd0);
    void'(sb.pop_front());
    f0 = fault_cycles;
    drive(TMO - 1, 1'b1, W'(12), 3'd1);
    e = sb.pop_front();
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL coincide_sample: got %h expected %h", got, e);
    end
    repeat (5) @(posedge clk);
    #1;
    e = expect_of(3'd1, last_wc, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL coincide_after: got %h expected %h", got, e);
    end
    vectors++;
    if (fault_cycles !== f0) begin
      miscompares++;
      $display("FAIL coincide_fault_cycles: got %0d expected %0d", fault_cycles - f0, 0);
    end
  endtask

  task automatic test_capture_reset();
    obs_t e, got;
    logic [2:0]  st[16] = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] pt = 16'b0000_0000_0000_0111;
    do_reset();
    drive(10, 1'b0, W'(4242), 3'd0);
    e = sb.pop_front();
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL capture: got %h expected %h", got, e);
    end
    @(posedge clk);
    #1;
    e = expect_of(3'd0, W'(4242), 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL capture_pulse_end: got %h expected %h", got, e);
    end
    run_table("capture_to_stop", 3, pt, st, 10);
    #2;
    rst = 1'b1;
    #1;
    e = expect_of(3'd0, '0, 1'b0);
    got = observe();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", got, e);
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.detection_valid   = 1'b0;
    bus.crossing_detected = 1'b0;
    bus.white_count       = '0;
    last_wc               = '0;
    test_reset();
    test_entry();
    test_min_hold();
    test_release_abort();
    test_back_to_back();
    test_watchdog();
    test_coincidence();
    test_capture_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
